// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: writes rotate across four line buffers while three
// completed lines are read in lock-step to form a vertical 3-pixel window column.
module line_buffer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int IMG_WIDTH = 512,
  parameter int CNT_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     pixel_in,
  input  logic                 pixel_in_valid,
  output logic [WIDTH-1:0]     lb_data_in,
  output logic [3:0]           lb_wr_valid,
  output logic [3:0]           lb_rd_en,
  input  logic [4*WIDTH-1:0]   lb_data_out,
  output logic [3*WIDTH-1:0]   window_col,
  output logic                 window_valid,
  output logic                 line_done,
  output logic                 overflow
);

  localparam logic [CNT_BITS-1:0] LINE_LAST  = CNT_BITS'(IMG_WIDTH - 1);
  localparam logic [CNT_BITS-1:0] FILL_FULL  = CNT_BITS'(4 * IMG_WIDTH);
  localparam logic [CNT_BITS-1:0] FILL_START = CNT_BITS'(3 * IMG_WIDTH);
  localparam logic [CNT_BITS-1:0] ONE        = CNT_BITS'(1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [1:0]            wr_sel_q, wr_sel_d;
  logic [1:0]            rd_sel_q, rd_sel_d;
  logic [CNT_BITS-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_BITS-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_BITS-1:0]   fill_q, fill_d;
  logic [3*WIDTH-1:0]    window_col_q, window_col_d;
  logic                  window_valid_q, window_valid_d;
  logic                  line_done_q, line_done_d;
  logic                  overflow_q, overflow_d;

  logic                  full_s;
  logic                  accept_s;
  logic                  read_s;
  logic [1:0]            rd_sel1_s;
  logic [1:0]            rd_sel2_s;

  // Strobes are masked by reset so no buffer moves while the block is held.
  always_comb begin
    full_s      = (fill_q == FILL_FULL);
    accept_s    = pixel_in_valid & ~full_s & ~reset;
    read_s      = (state_q == READ) & ~reset;
    rd_sel1_s   = rd_sel_q + 2'd1;
    rd_sel2_s   = rd_sel_q + 2'd2;
    lb_data_in  = pixel_in;
    lb_wr_valid = 4'b0000;
    lb_rd_en    = 4'b0000;
    if (accept_s) begin
      lb_wr_valid[wr_sel_q] = 1'b1;
    end else begin
      lb_wr_valid = 4'b0000;
    end
    if (read_s) begin
      lb_rd_en[rd_sel_q]  = 1'b1;
      lb_rd_en[rd_sel1_s] = 1'b1;
      lb_rd_en[rd_sel2_s] = 1'b1;
    end else begin
      lb_rd_en = 4'b0000;
    end
  end

  // Next-state for counters, fill level, read FSM and window register.
  always_comb begin
    state_d        = state_q;
    wr_sel_d       = wr_sel_q;
    rd_sel_d       = rd_sel_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    window_col_d   = window_col_q;
    window_valid_d = (state_q == READ);
    line_done_d    = 1'b0;
    overflow_d     = overflow_q | (pixel_in_valid & full_s);

    if (accept_s) begin
      if (wr_cnt_q == LINE_LAST) begin
        wr_cnt_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + ONE;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    case ({accept_s, read_s})
      2'b10:   fill_d = fill_q + ONE;
      2'b01:   fill_d = fill_q - ONE;
      default: fill_d = fill_q;
    endcase

    case (state_q)
      IDLE: begin
        if (fill_q >= FILL_START) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Oldest line (rd_sel) lands in the MSBs.
        window_col_d = {lb_data_out[int'(rd_sel_q) * WIDTH +: WIDTH],
                        lb_data_out[int'(rd_sel1_s) * WIDTH +: WIDTH],
                        lb_data_out[int'(rd_sel2_s) * WIDTH +: WIDTH]};
        if (rd_cnt_q == LINE_LAST) begin
          state_d     = IDLE;
          rd_cnt_d    = '0;
          rd_sel_d    = rd_sel_q + 2'd1;
          line_done_d = 1'b1;
        end else begin
          rd_cnt_d    = rd_cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_sel_q       <= 2'd0;
      rd_sel_q       <= 2'd0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      fill_q         <= '0;
      window_col_q   <= '0;
      window_valid_q <= 1'b0;
      line_done_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_sel_q       <= wr_sel_d;
      rd_sel_q       <= rd_sel_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      fill_q         <= fill_d;
      window_col_q   <= window_col_d;
      window_valid_q <= window_valid_d;
      line_done_q    <= line_done_d;
      overflow_q     <= overflow_d;
    end
  end

  assign window_col   = window_col_q;
  assign window_valid = window_valid_q;
  assign line_done    = line_done_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 512: pixels per image line, equal to the depth of each attached line buffer.
REQ-003 Parameter CNT_BITS, default 12: width of the fill counter, sized for 4*IMG_WIDTH.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pixel_in  input  WIDTH  incoming pixel.
REQ-007 pixel_in_valid  input  1  pixel_in is valid this cycle.
REQ-008 lb_data_in  output  WIDTH  pixel broadcast to all four line buffers; combinational copy of pixel_in.
REQ-009 lb_wr_valid  output  4  one-hot write strobe, bit i to line buffer i.
REQ-010 lb_rd_en  output  4  read-advance strobe; three bits set during READ.
REQ-011 lb_data_out  input  4*WIDTH  current read outputs of buffers 0..3; buffer i on bits [i*WIDTH +: WIDTH].
REQ-012 window_col  output  3*WIDTH  registered 3-row column; oldest line in the MSBs.
REQ-013 window_valid  output  1  window_col is valid this cycle.
REQ-014 line_done  output  1  one-cycle pulse after a full line has been read.
REQ-015 overflow  output  1  sticky flag; set when a write is dropped.

Function
REQ-016 wr_sel (2 bits) SHALL select the buffer being written: lb_wr_valid = pixel_in_valid & ~full, shifted to bit wr_sel.
REQ-017 wr_cnt SHALL count accepted writes; at IMG_WIDTH-1 it SHALL wrap to 0 and wr_sel SHALL increment modulo 4.
REQ-018 fill (CNT_BITS) SHALL track stored, unread pixels: +1 on accepted write, -1 on read cycle, unchanged on both or neither.
REQ-019 full SHALL be (fill == 4*IMG_WIDTH); a valid pixel arriving while full SHALL be dropped with no strobe, and overflow SHALL be set until reset.
REQ-020 The FSM SHALL have states IDLE and READ.
REQ-021 IDLE -> READ when fill >= 3*IMG_WIDTH; otherwise remain in IDLE.
REQ-022 In READ, lb_rd_en SHALL assert bits rd_sel, rd_sel+1 and rd_sel+2 (modulo 4) every cycle.
REQ-023 rd_cnt SHALL count READ cycles; on rd_cnt == IMG_WIDTH-1 the FSM SHALL return to IDLE, rd_cnt SHALL clear, and rd_sel SHALL increment modulo 4.
REQ-024 line_done SHALL pulse high on the cycle after the last READ cycle.
REQ-025 window_col SHALL register {lb_data_out[rd_sel], lb_data_out[rd_sel+1], lb_data_out[rd_sel+2]} on every READ cycle.
REQ-026 window_valid SHALL equal the READ state delayed by one cycle (latency 1).
REQ-027 window_col SHALL hold its value when window_valid is low.
REQ-028 Writes SHALL continue during READ; the buffer at rd_sel+3 is the only one written then, so no buffer is read and written in the same line period.
REQ-029 A full line written and a line read in the same cycle window SHALL leave fill exact (REQ-018 handles simultaneous events).
REQ-030 The FSM SHALL spend at least one IDLE cycle between consecutive lines.

Reset
REQ-031 On reset, the following SHALL clear to 0 at the next edge, regardless of state, including mid-READ: wr_sel, rd_sel, wr_cnt, rd_cnt, fill, window_col, window_valid, line_done and overflow; the state SHALL become IDLE.
REQ-032 While reset is high, lb_wr_valid and lb_rd_en SHALL be 0.

Verification (IMG_WIDTH=4 for the bench)
REQ-033 Write 12 consecutive valid pixels 1..12 -> lb_wr_valid cycles 0001 x4, 0010 x4, 0100 x4; READ entered the cycle after fill==12; lb_rd_en=0111 for 4 cycles; window_valid for 4 cycles; line_done one pulse.
REQ-034 Model the buffers behaviourally with lines 1-4 / 5-8 / 9-12 -> window_col = {1,5,9},{2,6,10},{3,7,11},{4,8,12}; afterwards rd_sel=1 and fill=8.
REQ-035 Stream 20 pixels continuously -> second READ uses lb_rd_en=1110, third uses 1101; wr_sel wraps 3->0; no overflow.
REQ-036 Write 17 pixels with reads stalled (buffer model only, FSM held by forcing fill check via no READ: hold pixel stream before 12, then burst) -> the 17th write while fill==16 is dropped, overflow=1 and stays 1.
REQ-037 Assert reset for 1 cycle during the 2nd READ cycle -> next cycle state IDLE, all outputs 0, fill=0; a following 12-pixel stream reproduces REQ-033 exactly.
REQ-038 Pixel_in_valid toggling every other cycle -> write strobes only on valid cycles; fill counts exactly; READ starts only after the 12th accepted pixel.
